dot_product_sequencer: RTL
==========================

# dot_product_sequencer

Sequential stage that drives the combinational signed 8-bit multiplier to compute one matrix-element dot product, row(A)·column(B), for vectors of up to 5 elements. It feeds one operand pair per cycle to the multiplier and accumulates the returned products into a saturating signed 8-bit sum with a sticky overflow flag. It sits between the coprocessor's matrix-multiply control and the multiplier, which is instantiated outside this block and connected through the `mul_*` ports.

## Interface
Parameters:
- `N_MAX`, 5: maximum vector length.
- `W`, 8: element and result width, signed two's complement.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `len`  in  3  vector length; 0 and values above `N_MAX` are allowed (see Operation).
- `vec_a`  in  N_MAX*W  row vector, element i at bits [W*i+W-1 : W*i].
- `vec_b`  in  N_MAX*W  column vector, same packing as `vec_a`.
- `mul_a`, `mul_b`  out  W  operands to the multiplier.
- `mul_rst`  out  1  multiplier reset; held high except in RUN.
- `mul_prod`  in  W  signed product from the multiplier, low byte.
- `mul_ovf`  in  1  multiplier overflow flag.
- `result`  out  W  signed dot product, registered.
- `ovf`  out  1  sticky overflow flag for the current operation.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse in DONE.

## Operation
- Reset: state IDLE. `result`=0, `ovf`=0, `busy`=0, `done`=0, `mul_a`=0, `mul_b`=0, `mul_rst`=1, index=0, accumulator=0.
- States: IDLE, RUN, DONE.
- **IDLE**
  - With `start`=1: latch `vec_a`, `vec_b` and the effective length `n_eff`; clear the accumulator, `ovf` and the index.
  - `n_eff` = min(`len`, `N_MAX`).
  - If `n_eff`=0, go to DONE. Otherwise go to RUN.
  - `result` holds its last value until it is overwritten.
- **RUN**
  - `mul_a` and `mul_b` are driven combinationally from latched element[index].
  - Each cycle the accumulator updates to `sat(acc + mul_prod)`.
  - `ovf` is set to `ovf | mul_ovf | add_ovf`.
  - The index increments each cycle. After the cycle where index = `n_eff`-1, the accumulator is copied to `result` and the state goes to DONE.
- **DONE**
  - `done`=1 and `busy`=1 for exactly one cycle, then IDLE.
  - `result` and `ovf` stay stable until the next accepted `start`.
- Arithmetic
  - The sum is formed at W+1 bits with both operands sign-extended.
  - Above 127: saturate to 127 and set `add_ovf`.
  - Below -128: saturate to -128 and set `add_ovf`.
  - `mul_prod` is used as delivered; if it was truncated, `mul_ovf` records that.
- Boundary cases
  - `start` while `busy` is ignored, with no latch and no effect.
  - `rst` has priority over all other inputs in every state. Asserting it in RUN aborts the operation, and reset values apply after that edge.
  - Once `ovf` is set it is never cleared mid-operation. Saturation continues on later products.

## Timing
- The start edge is E0.
- RUN occupies the cycles after edges E0 through E(n_eff-1).
- `done` is high in the cycle after edge E(n_eff), so latency is n_eff+1 cycles from the start edge to `done`.
- With `n_eff`=0, `done` is high in the cycle after E0.
- `result` and `ovf` are valid in the same cycle as `done`.
- Throughput: one operation per n_eff+2 cycles, because one IDLE cycle is needed to accept the next `start`.
- Multiplier path: latched operand register → mux → `mul_a`/`mul_b` → external combinational multiplier → `mul_prod` → saturating adder → accumulator. This is a single-cycle path, and the design must close timing on it.

## Structure
- Shared package `coproc_pkg` contains:
  - the state enum (IDLE, RUN, DONE);
  - `N_MAX` and `W` defaults;
  - the constants `SAT_MAX`=127 and `SAT_MIN`=-128;
  - the function `sat_add` (W-bit inputs, returns the sum plus an overflow bit).
- No sub-module is needed. The existing `multiplier` stays outside and is wired by the parent matrix-multiply block, so it can be shared or replaced.

## Test plan
- len=3, A=[1,2,3], B=[4,5,6] → `result`=32, `ovf`=0, `done` 4 cycles after the start edge, `busy` high for 4 cycles.
- len=2, A=[-3,4], B=[5,-2] → `result`=-23, `ovf`=0.
- len=2, A=[100,100], B=[1,1] → `result`=127, `ovf`=1. Also A=[-100,-100], B=[1,1] → `result`=-128, `ovf`=1.
- len=1, A=[16], B=[16] → multiplier returns `mul_prod`=0 with `mul_ovf`=1 → `result`=0, `ovf`=1.
- `rst` pulsed in the second RUN cycle of a len=5 operation → next cycle `busy`=0, `done`=0, `result`=0, `ovf`=0, `mul_rst`=1. Separately, `start` re-asserted during RUN → ignored, original result unchanged.
- len=0 → `done` the cycle after the start edge with `result`=0. len=7 with all-ones vectors (element value 1) → clamped to 5, `result`=5, latency 6 cycles.

Source files
------------

// File: rtl/dot_product_sequencer_pkg.sv
// Shared coprocessor definitions: FSM states, datapath widths and the
// saturating signed adder used by the dot-product accumulator.
package coproc_pkg;

  localparam int unsigned N_MAX = 5;
  localparam int unsigned W     = 8;

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Returns {overflow, saturated_sum}; the sum is formed one bit wider so the
  // two top bits disagree exactly when the W-bit result would have wrapped.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) begin
      return {1'b1, (s[W] ? SAT_MIN : SAT_MAX)};
    end
    return {1'b0, s[W-1:0]};
  endfunction

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Request/result bus of the dot-product sequencer plus its link to the
// external combinational multiplier.
interface dot_product_sequencer_if #(
  parameter int unsigned N_MAX = coproc_pkg::N_MAX,
  parameter int unsigned W     = coproc_pkg::W
);

  logic               start;
  logic [2:0]         len;
  logic [N_MAX*W-1:0] vec_a;
  logic [N_MAX*W-1:0] vec_b;
  logic [W-1:0]       mul_a;
  logic [W-1:0]       mul_b;
  logic               mul_rst;
  logic [W-1:0]       mul_prod;
  logic               mul_ovf;
  logic [W-1:0]       result;
  logic               ovf;
  logic               busy;
  logic               done;

  // Control plus multiplier side
  modport master (
    output start, len, vec_a, vec_b, mul_prod, mul_ovf,
    input  mul_a, mul_b, mul_rst, result, ovf, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, len, vec_a, vec_b, mul_prod, mul_ovf,
    output mul_a, mul_b, mul_rst, result, ovf, busy, done
  );

endinterface

// File: rtl/dot_product_sequencer.sv
// Feeds one operand pair per cycle to an external multiplier and accumulates
// the products into a saturating signed sum with a sticky overflow flag.
module dot_product_sequencer
  import coproc_pkg::*;
#(
  parameter int unsigned N_MAX = coproc_pkg::N_MAX,
  parameter int unsigned W     = coproc_pkg::W
) (
  input  logic                   clk,
  input  logic                   rst,
  dot_product_sequencer_if.slave bus
);

  state_e             state_q, state_d;
  logic [N_MAX*W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]         n_q, n_d, idx_q, idx_d;
  logic [W-1:0]       acc_q, acc_d, result_q, result_d;
  logic               ovf_q, ovf_d;

  logic [2:0]         n_eff;
  logic [W:0]         sum;
  logic               last;

  assign n_eff = (bus.len > 3'(N_MAX)) ? 3'(N_MAX) : bus.len;
  assign sum   = sat_add(acc_q, bus.mul_prod);
  assign last  = (idx_q == n_q - 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (bus.start) state_d = (n_eff == 3'd0) ? StDone : StRun;
      StRun:  if (last) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.mul_a   = '0;
    bus.mul_b   = '0;
    bus.mul_rst = 1'b1;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (state_q)
      StRun: begin
        bus.mul_a   = a_q[W*idx_q +: W];
        bus.mul_b   = b_q[W*idx_q +: W];
        bus.mul_rst = 1'b0;
        bus.busy    = 1'b1;
      end
      StDone: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d   = bus.vec_a;
          b_d   = bus.vec_b;
          n_d   = n_eff;
          idx_d = '0;
          acc_d = '0;
          ovf_d = 1'b0;
          // An empty dot product is zero, so it overwrites the old result.
          if (n_eff == 3'd0) result_d = '0;
        end
      end
      StRun: begin
        acc_d = sum[W-1:0];
        ovf_d = ovf_q | bus.mul_ovf | sum[W];
        idx_d = idx_q + 3'd1;
        if (last) result_d = sum[W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
